// File: rtl/ff_fifo_pkt_rollback.sv
// Flop-based AXI-stream packet FIFO with write rollback: only committed packets reach downstream.
// Define FF_FIFO_OVERFLOW_DROP_EN to discard packets that alone would overflow the FIFO.
module ff_fifo_pkt_rollback #(
  parameter int D_WIDTH   = 8,
  parameter int DEPTH     = 12,
  parameter int CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [D_WIDTH-1:0]         up_data,
  input  logic                       up_last,
  input  logic                       up_drop,
  input  logic                       up_valid,
  output logic                       up_ready,
  output logic [D_WIDTH-1:0]         down_data,
  output logic                       down_last,
  output logic                       down_valid,
  input  logic                       down_ready,
  output logic [$clog2(DEPTH+1)-1:0] pkt_count,
  output logic [CNT_WIDTH-1:0]       drop_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  typedef enum logic {ACCEPT, DISCARD} state_e;

  logic [D_WIDTH:0]   mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, cm_ptr_q, cm_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      wr_lvl_q, wr_lvl_d, cm_lvl_q, cm_lvl_d, pkt_q, pkt_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d, drop_inc;
  state_e             state_q, state_d;
  logic               push, pop, wr_en, store;
  logic [LW-1:0]      pop_n;
  logic [PW-1:0]      wr_inc;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign up_ready   = (state_q == DISCARD) || (wr_lvl_q != LW'(DEPTH));
  assign down_valid = (cm_lvl_q != '0);
  assign down_data  = mem_q[rd_ptr_q][D_WIDTH-1:0];
  assign down_last  = mem_q[rd_ptr_q][D_WIDTH];
  assign pkt_count  = pkt_q;
  assign drop_count = drop_q;

  assign push     = up_valid & up_ready;
  assign pop      = down_valid & down_ready;
  assign pop_n    = LW'(pop);
  assign wr_en    = push & (state_q == ACCEPT);
  assign store    = wr_en & ~(up_last & up_drop);
  assign wr_inc   = nxt(wr_ptr_q);
  assign drop_inc = (drop_q == '1) ? drop_q : drop_q + CNT_WIDTH'(1);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    cm_ptr_d = cm_ptr_q;
    rd_ptr_d = pop ? nxt(rd_ptr_q) : rd_ptr_q;
    wr_lvl_d = wr_lvl_q - pop_n;
    cm_lvl_d = cm_lvl_q - pop_n;
    pkt_d    = pkt_q - LW'(pop & down_last);
    drop_d   = drop_q;
    state_d  = state_q;
    if (wr_en) begin
      if (!up_last) begin
        wr_ptr_d = wr_inc;
        wr_lvl_d = wr_lvl_q + LW'(1) - pop_n;
      end else if (!up_drop) begin
        wr_ptr_d = wr_inc;
        cm_ptr_d = wr_inc;
        wr_lvl_d = wr_lvl_q + LW'(1) - pop_n;
        cm_lvl_d = wr_lvl_q + LW'(1) - pop_n;
        pkt_d    = pkt_q + LW'(1) - LW'(pop & down_last);
      end else begin
        // Rollback: forget every uncommitted beat.
        wr_ptr_d = cm_ptr_q;
        wr_lvl_d = cm_lvl_q - pop_n;
        drop_d   = drop_inc;
      end
    end
`ifdef FF_FIFO_OVERFLOW_DROP_EN
    // A packet that fills the FIFO by itself can never commit; shed it and swallow its tail.
    if (state_q == ACCEPT && up_valid && wr_lvl_q == LW'(DEPTH) && cm_lvl_q == '0) begin
      wr_ptr_d = cm_ptr_q;
      wr_lvl_d = '0;
      drop_d   = drop_inc;
      state_d  = DISCARD;
    end
    if (state_q == DISCARD && up_valid && up_last) state_d = ACCEPT;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      cm_ptr_q <= '0;
      rd_ptr_q <= '0;
      wr_lvl_q <= '0;
      cm_lvl_q <= '0;
      pkt_q    <= '0;
      drop_q   <= '0;
      state_q  <= ACCEPT;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      cm_ptr_q <= cm_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_lvl_q <= wr_lvl_d;
      cm_lvl_q <= cm_lvl_d;
      pkt_q    <= pkt_d;
      drop_q   <= drop_d;
      state_q  <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (store) mem_q[wr_ptr_q] <= {up_last, up_data};
  end
endmodule

// File: tb/tb_ff_fifo_pkt_rollback.sv
// Directed bench for ff_fifo_pkt_rollback (DEPTH=12): vector table plus hand-written corner sequences.
module tb_ff_fifo_pkt_rollback;
  logic       clk = 0;
  logic       rst;
  logic [7:0] up_data;
  logic       up_last, up_drop, up_valid, up_ready;
  logic [7:0] down_data;
  logic       down_last, down_valid, down_ready;
  logic [3:0] pkt_count;
  logic [7:0] drop_count;

  int n_cmp = 0;
  int n_bad = 0;

  ff_fifo_pkt_rollback #(.D_WIDTH(8), .DEPTH(12), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .up_data(up_data), .up_last(up_last), .up_drop(up_drop),
    .up_valid(up_valid), .up_ready(up_ready),
    .down_data(down_data), .down_last(down_last), .down_valid(down_valid),
    .down_ready(down_ready), .pkt_count(pkt_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       l, dr, v, dn;
    logic       e_rdy, e_val;
    logic [7:0] e_data;
    logic       e_last;
    logic [3:0] e_pkt;
    logic [7:0] e_drop;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] d, input logic l, dr, v, dn,
                     input logic e_rdy, e_val, input logic [7:0] e_data,
                     input logic e_last, input logic [3:0] e_pkt, input logic [7:0] e_drop);
    vec_t t;
    t = '{d, l, dr, v, dn, e_rdy, e_val, e_data, e_last, e_pkt, e_drop};
    vecs.push_back(t);
  endtask

  task automatic drive(input logic [7:0] d, input logic l, dr, v, dn);
    up_data = d; up_last = l; up_drop = dr; up_valid = v; down_ready = dn;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  logic [8:0] sb[$];
  logic [8:0] exp_beat;

  initial begin
    rst = 1;
    drive(8'h00, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    //   data   l  dr v  dn | rdy val data   last pkt drop
    add(8'h00, 0, 0, 0, 0,   1, 0, 8'h00, 0, 0, 0);  // reset state
    add(8'hA0, 0, 0, 1, 0,   1, 0, 8'h00, 0, 0, 0);
    add(8'hA1, 0, 0, 1, 0,   1, 0, 8'h00, 0, 0, 0);
    add(8'hA2, 1, 0, 1, 0,   1, 0, 8'h00, 0, 0, 0);
    add(8'h00, 0, 0, 0, 1,   1, 1, 8'hA0, 0, 1, 0);  // visible cycle after commit
    add(8'h00, 0, 0, 0, 1,   1, 1, 8'hA1, 0, 1, 0);
    add(8'h00, 0, 0, 0, 1,   1, 1, 8'hA2, 1, 1, 0);
    add(8'h00, 0, 0, 0, 0,   1, 0, 8'h00, 0, 0, 0);
    add(8'hB0, 0, 0, 1, 0,   1, 0, 8'h00, 0, 0, 0);
    add(8'hB1, 0, 0, 1, 0,   1, 0, 8'h00, 0, 0, 0);
    add(8'hB2, 1, 1, 1, 0,   1, 0, 8'h00, 0, 0, 0);  // drop B
    add(8'hC0, 0, 0, 1, 0,   1, 0, 8'h00, 0, 0, 1);
    add(8'hC1, 1, 0, 1, 0,   1, 0, 8'h00, 0, 0, 1);
    add(8'h00, 0, 0, 0, 1,   1, 1, 8'hC0, 0, 1, 1);
    add(8'h00, 0, 0, 0, 1,   1, 1, 8'hC1, 1, 1, 1);
    add(8'h00, 0, 0, 0, 0,   1, 0, 8'h00, 0, 0, 1);
    add(8'hD0, 1, 0, 1, 0,   1, 0, 8'h00, 0, 0, 1);
    add(8'hE0, 0, 0, 1, 0,   1, 1, 8'hD0, 1, 1, 1);
    add(8'hE1, 1, 1, 1, 1,   1, 1, 8'hD0, 1, 1, 1);  // pop last committed + drop push
    add(8'h00, 0, 0, 0, 0,   1, 0, 8'h00, 0, 0, 2);
    add(8'hF0, 1, 0, 1, 0,   1, 0, 8'h00, 0, 0, 2);
    add(8'h00, 0, 0, 0, 1,   1, 1, 8'hF0, 1, 1, 2);
    add(8'h00, 0, 0, 0, 0,   1, 0, 8'h00, 0, 0, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].d, vecs[i].l, vecs[i].dr, vecs[i].v, vecs[i].dn);
      @(negedge clk);
      check($sformatf("v%0d_up_ready", i), up_ready, vecs[i].e_rdy);
      check($sformatf("v%0d_down_valid", i), down_valid, vecs[i].e_val);
      check($sformatf("v%0d_pkt_count", i), pkt_count, vecs[i].e_pkt);
      check($sformatf("v%0d_drop_count", i), drop_count, vecs[i].e_drop);
      if (vecs[i].e_val) begin
        check($sformatf("v%0d_down_data", i), down_data, vecs[i].e_data);
        check($sformatf("v%0d_down_last", i), down_last, vecs[i].e_last);
      end
      tick();
    end

    // Fill exactly to DEPTH with one 12-beat packet.
    for (int i = 0; i < 12; i++) begin
      drive(8'h10 + 8'(i), i == 11, 0, 1, 0);
      sb.push_back({i == 11, 8'h10 + 8'(i)});
      tick();
    end
    drive(8'h00, 0, 0, 0, 1);
    @(negedge clk);
    check("full_up_ready", up_ready, 0);
    check("full_pkt_count", pkt_count, 1);
    check("full_down_valid", down_valid, 1);
    exp_beat = sb.pop_front();
    check("full_pop_beat", {down_last, down_data}, exp_beat);
    tick();
    down_ready = 0;
    @(negedge clk);
    check("freed_up_ready", up_ready, 1);
    tick();

    // Stream 40 beats in 4-beat packets with random pops, across pointer wrap.
    begin
      int j = 0;
      int cyc = 0;
      while ((j < 40 || sb.size() > 0) && cyc < 2000) begin
        drive(8'h40 + 8'(j), (j % 4) == 3, 0, j < 40, 1'($urandom_range(0, 1)));
        @(negedge clk);
        if (down_valid && down_ready) begin
          if (sb.size() == 0) check("stream_unexpected_pop", 1, 0);
          else begin
            exp_beat = sb.pop_front();
            check("stream_beat", {down_last, down_data}, exp_beat);
          end
        end
        if (up_valid && up_ready) begin
          sb.push_back({up_last, up_data});
          j++;
        end
        tick();
        cyc++;
      end
      drive(8'h00, 0, 0, 0, 0);
      check("stream_complete", (j == 40) && (sb.size() == 0), 1);
    end
    @(negedge clk);
    check("stream_pkt_count", pkt_count, 0);
    check("stream_down_valid", down_valid, 0);
    check("stream_drop_count", drop_count, 2);
    tick();

    // Reset in the middle of a packet.
    for (int i = 0; i < 5; i++) begin
      drive(8'h60 + 8'(i), 0, 0, 1, 0);
      tick();
    end
    drive(8'h00, 0, 0, 0, 0);
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    check("rst_up_ready", up_ready, 1);
    check("rst_down_valid", down_valid, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_drop_count", drop_count, 0);
    tick();
    drive(8'h70, 0, 0, 1, 0); tick();
    drive(8'h71, 1, 0, 1, 0); tick();
    drive(8'h00, 0, 0, 0, 1);
    @(negedge clk);
    check("rst_g0", {down_valid, down_last, down_data}, {1'b1, 1'b0, 8'h70});
    tick();
    @(negedge clk);
    check("rst_g1", {down_valid, down_last, down_data}, {1'b1, 1'b1, 8'h71});
    tick();
    down_ready = 0;

    // Oversize 15-beat packet with no pops.
    begin
      int k = 0;
      int stalls = 0;
      for (int c = 0; c < 40 && k < 15; c++) begin
        drive(8'h80 + 8'(k), k == 14, 0, 1, 0);
        @(negedge clk);
        if (up_ready) k++;
        else stalls++;
        tick();
      end
      drive(8'h00, 0, 0, 0, 0);
      @(negedge clk);
`ifdef FF_FIFO_OVERFLOW_DROP_EN
      check("ovf_beats_taken", k, 15);
      check("ovf_stalls", stalls, 1);
      check("ovf_drop_count", drop_count, 1);
      check("ovf_down_valid", down_valid, 0);
      check("ovf_pkt_count", pkt_count, 0);
      check("ovf_up_ready", up_ready, 1);
      tick();
      drive(8'h90, 1, 0, 1, 0); tick();
      drive(8'h00, 0, 0, 0, 1);
      @(negedge clk);
      check("ovf_next_pkt", {down_valid, down_last, down_data}, {1'b1, 1'b1, 8'h90});
      tick();
`else
      check("hang_beats_taken", k, 12);
      check("hang_up_ready", up_ready, 0);
      check("hang_down_valid", down_valid, 0);
      check("hang_drop_count", drop_count, 0);
`endif
    end

    drive(8'h00, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ff_fifo_pkt_rollback.md
Name: ff_fifo_pkt_rollback

Overview:
- AXI-stream flop-based packet FIFO with write rollback, for any depth (not limited to powers of two).
- tlast and drop are explicit sideband ports rather than packed data MSBs.
- Downstream only ever sees complete, committed packets.
- Also reports the committed packet count and a saturating dropped-packet counter.
- Sits between a packet parser/checker (which marks bad packets late, on the last beat) and downstream consumers.

Parameters:
- D_WIDTH, 8, payload width in bits.
- DEPTH, 12, number of entries; any integer >= 2.
- CNT_WIDTH, 8, width of drop_count.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- up_data  in  D_WIDTH  write payload
- up_last  in  1  last beat of packet
- up_drop  in  1  discard current packet; sampled only on a beat with up_last=1
- up_valid  in  1  write valid
- up_ready  out  1  write ready
- down_data  out  D_WIDTH  read payload
- down_last  out  1  stored last flag of head entry
- down_valid  out  1  read valid (committed data available)
- down_ready  in  1  read ready
- pkt_count  out  $clog2(DEPTH+1)  committed packets currently held
- drop_count  out  CNT_WIDTH  dropped packets since reset, saturating

Behaviour:
- push = up_valid & up_ready; pop = down_valid & down_ready.
- Storage: DEPTH entries of {last, data}; not reset.
- Pointers wr_ptr, commit_ptr, rd_ptr each range 0..DEPTH-1; an increment from DEPTH-1 wraps to 0 explicitly.
- wr_level (0..DEPTH): entries written, committed or not, minus entries popped.
- cm_level (0..DEPTH): committed entries not yet popped.
- up_ready = (wr_level != DEPTH). down_valid = (cm_level != 0).
- down_data/down_last = entry at rd_ptr (combinational read); both are don't-care while down_valid=0.
- Normal push (~up_last): store beat at wr_ptr; wr_ptr++; wr_level++.
- Commit push (up_last & ~up_drop): store beat; wr_ptr++; commit_ptr <= new wr_ptr; cm_level <= wr_level+1 (net of a same-cycle pop); pkt_count++.
- Drop push (up_last & up_drop): beat consumed, not stored; wr_ptr <= commit_ptr; wr_level <= cm_level (net of a same-cycle pop); drop_count++ unless all ones.
- up_drop without up_last: ignored.
- Pop: rd_ptr++; wr_level--; cm_level--; pkt_count-- if popped entry has last=1.
- Simultaneous push and pop: both levels updated by net amount in one cycle. pkt_count +1 and -1 in the same cycle cancel.
- Latency:
  - Committed beats are visible on down_valid the cycle after the commit push (registered levels).
  - A slot freed by pop is visible on up_ready the next cycle.
- Full boundary:
  - wr_level==DEPTH: up_ready=0.
  - A packet longer than DEPTH with cm_level==0 can never complete (see optional feature).
- Reset values: wr_ptr=commit_ptr=rd_ptr=0, levels 0, up_ready=1, down_valid=0, pkt_count=0, drop_count=0, state ACCEPT.
- Reset mid-packet discards all contents, including the partial packet.
- State machine (ACCEPT, DISCARD): only DISCARD exists under the optional feature; otherwise the block is permanently ACCEPT.

Optional Feature:
- FF_FIFO_OVERFLOW_DROP_EN defined:
  - In ACCEPT, if up_valid & wr_level==DEPTH & cm_level==0 (packet alone fills FIFO):
    - wr_ptr <= commit_ptr, wr_level <= 0;
    - drop_count++ (saturating);
    - go to DISCARD.
  - In DISCARD: up_ready=1; beats are consumed and not stored. The beat with up_last returns to ACCEPT next cycle, with no further drop_count increment.
  - If the FIFO is full with cm_level>0, it stalls as normal.
- Undefined: no DISCARD state; up_ready=0 while full. An oversize packet is an upstream contract violation and hangs the FIFO.

Test Plan:
- DEPTH=12, push 3-beat packet A0,A1,A2(last) -> down_valid rises the cycle after A2; pops A0,A1,A2 with down_last on A2; pkt_count 1 -> 0.
- Push B0,B1, then B2 with last+drop, then packet C of 2 beats -> only C emerges; drop_count=1; wr_ptr restored before C0 is written.
- Push 11 beats + last (12) with no pops -> up_ready=0, pkt_count=1; one pop -> up_ready=1 next cycle. Keep streaming 40 beats in 4-beat packets with random pops -> data order exact across the wrap at index 11->0.
- Pop the last committed beat in the same cycle as a drop push -> cm_level=wr_level=0, down_valid=0 next cycle, no stale data returned.
- rst asserted mid-packet after 5 uncommitted beats -> all counters 0, up_ready=1, down_valid=0; the next packet passes intact.
- Macro on, 15-beat packet with no pops -> after 12 beats the block enters DISCARD, accepts the remaining 3 beats, drop_count=1, FIFO empty. Macro off -> up_ready stays 0.
